// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter
// One shared delay counter, lent to up to N_REQ requesters in round-robin
// order. The owner holds req high while it waits. It gets a one-cycle done
// pulse exactly target cycles after its grant rises. Dropping req early
// releases the counter without a done pulse.
module delay_timer_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 31,
   parameter int IDX_W = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CNT_W-1:0] delay_len,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [IDX_W-1:0]       owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_next;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] target_next;
   logic [N_REQ-1:0] grant_next;
   logic [N_REQ-1:0] done_next;
   logic [IDX_W-1:0] owner_next;
   logic [IDX_W-1:0] rr_ptr;       // first index to scan on the next arbitration
   logic [IDX_W-1:0] rr_ptr_next;
   logic [IDX_W-1:0] owner_succ;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [CNT_W-1:0] pick_len;
   logic             expire;
   logic             abort;

   // One length slice per requester, taken from the flat bus.
   logic [CNT_W-1:0] len_arr [N_REQ];
   for (genvar g = 0; g < N_REQ; g++) begin : g_len
      assign len_arr[g] = delay_len[g*CNT_W +: CNT_W];
   end

   // Round-robin pick: the first requesting index at or after rr_ptr, with wrap.
   always_comb begin
      int cand;
      // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
      cand       = 0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!pick_valid && req[IDX_W'(cand)]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // A zero length would never expire, so it is treated as one cycle.
   assign pick_len   = (len_arr[pick_idx] == '0) ? CNT_W'(1) : len_arr[pick_idx];
   assign expire     = (counter == target - CNT_W'(1));
   assign abort      = ~req[owner];
   assign owner_succ = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
   assign busy       = |grant;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic. Expiry takes priority over a same-cycle req drop.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_valid) state_next = COUNT;
         COUNT: begin
            if (expire)     state_next = FINISH;
            else if (abort) state_next = IDLE;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values for the registered grant/done and the datapath.
   always_comb begin
      grant_next   = grant;
      done_next    = '0;
      owner_next   = owner;
      target_next  = target;
      counter_next = counter;
      rr_ptr_next  = rr_ptr;
      case (state)
         IDLE: begin
            grant_next   = '0;
            counter_next = '0;
            if (pick_valid) begin
               grant_next[pick_idx] = 1'b1;
               owner_next           = pick_idx;
               target_next          = pick_len;
            end
         end
         COUNT: begin
            counter_next = counter + CNT_W'(1);
            if (expire) begin
               done_next[owner] = 1'b1;
            end else if (abort) begin
               grant_next  = '0;
               rr_ptr_next = owner_succ;
            end
         end
         FINISH: begin
            grant_next  = '0;
            rr_ptr_next = owner_succ;
         end
         default: grant_next = '0;
      endcase
   end

   // Registered outputs and datapath, all cleared asynchronously by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant   <= '0;
         done    <= '0;
         owner   <= '0;
         target  <= '0;
         counter <= '0;
         rr_ptr  <= '0;
      end else begin
         grant   <= grant_next;
         done    <= done_next;
         owner   <= owner_next;
         target  <= target_next;
         counter <= counter_next;
         rr_ptr  <= rr_ptr_next;
      end
   end

endmodule
